bin_to_bcd_seq: RTL
===================

Name: bin_to_bcd_seq

Overview:
- Parametrised sequential binary-to-decimal converter using shift-and-add-3 (double dabble), one input bit per clock.
- Generalises the fixed 32-bit / 10-digit converter. Adds configurable width and digit count, an ASCII or raw-BCD output mode, and optional leading-zero blanking.
- Adds rising-edge start detection, an overflow flag and a significant-digit count.
- Sits between the frequency-count registers and the UART/display formatting logic.

Parameters:
- WIDTH, 32: binary input width, 1..64.
- DIGITS, 10: number of decimal digits produced, 1..20.
- ASCII, 1: 1 = each digit byte is 8'h30+d; 0 = each digit byte is {4'h0,d}.
- BLANK_LZ, 0: 1 = leading zero digits output as 8'h20 (ASCII=1) or 8'h0F (ASCII=0). Digit 0 is never blanked.

Ports:
- clk_i  in  1  system clock, all logic on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- bin_i  in  WIDTH  unsigned value to convert; sampled only at acceptance.
- start_i  in  1  conversion request; a rising edge is accepted.
- busy_o  out  1  high while a conversion is in progress.
- done_o  out  1  one-cycle pulse when the result registers update.
- valid_o  out  1  high once at least one result has been produced since reset.
- ovf_o  out  1  the last result lost a nonzero digit above DIGITS.
- digits_o  out  8*DIGITS  result; byte i = decimal digit i, byte 0 (LSB) = ones.
- ndigits_o  out  $clog2(DIGITS+1)  count of significant digits in the last result; a value of 0 gives 1.

Behaviour:
- Reset (asynchronous on rst_ni low): state IDLE, start_q=0, busy_o=0, done_o=0, valid_o=0, ovf_o=0, digits_o=all 8'h00, ndigits_o=0.
- Reset during a conversion aborts it; the partial result is discarded.
- Edge detect: start_q <= start_i every cycle. A request is accept = start_i & ~start_q & (state==IDLE).
  - Holding start_i high gives exactly one conversion.
  - Because start_q resets to 0, start_i held high through reset release counts as an edge.
- States:
  - IDLE: on accept, load shift register <= bin_i, bcd <= 0, ovf_acc <= 0, cnt <= 0, then go to SHIFT. Otherwise stay.
  - SHIFT: each cycle, first add 3 to every BCD digit whose value is >= 5. Then shift {bcd, shreg} left by one, with the shreg MSB entering bcd digit 0 LSB.
    - The bit shifted out of the top digit is ORed into ovf_acc.
    - cnt increments; after WIDTH iterations go to FINISH.
  - FINISH: register the outputs, pulse done_o=1, set valid_o=1, clear busy_o, go to IDLE.
- Latency:
  - Acceptance at edge k gives busy_o=1 after edges k..k+WIDTH.
  - done_o=1 and new digits_o/ovf_o/ndigits_o appear after edge k+WIDTH+1, i.e. WIDTH+1 cycles after acceptance.
  - done_o falls on the next edge.
- Back-to-back: the earliest next acceptance is in the cycle after FINISH, and requires start_i to have been low for at least one sampled cycle.
- Edges on start_i during SHIFT/FINISH are ignored and not queued; bin_i changes during a conversion are ignored.
- Outputs hold their value between conversions. They change only in FINISH or on reset.
- Overflow: if DIGITS is too small, the lower DIGITS digits remain correct (truncated) and ovf_o=1. Otherwise ovf_o=0.
- ndigits_o = index of the highest nonzero digit + 1; a value of 0 gives 1.
- Blanking (BLANK_LZ=1): digits with index >= ndigits_o use the blank code.
- Encoding is applied in FINISH; internal BCD is always 4-bit per digit.

Test Plan:
1. Defaults, bin_i=32'h61626364, single start pulse -> done_o pulse exactly 33 cycles after acceptance. digits_o = ASCII "1633837924" (byte9=8'h31 ... byte0=8'h34), ndigits_o=10, ovf_o=0, busy_o high for 33 cycles.
2. Defaults, start_i held high for 2000 ns -> exactly one done_o pulse. No further conversion until start_i goes low then high again.
3. WIDTH=8, DIGITS=2, ASCII=0, bin_i=8'd255 -> digits_o={8'h05,8'h05}, ovf_o=1. Then bin_i=8'd99 -> {8'h09,8'h09}, ovf_o=0.
4. Defaults with BLANK_LZ=1, bin_i=42 -> bytes 9..2=8'h20, byte1=8'h34, byte0=8'h32, ndigits_o=2. Then bin_i=0 -> byte0=8'h30, others 8'h20, ndigits_o=1.
5. rst_ni pulled low 10 cycles into a conversion -> all outputs at reset values immediately, no done_o. start_i still high at release -> new conversion is accepted on the first edge.
6. Defaults, bin_i=32'hFFFFFFFF, with bin_i changed and start_i toggled mid-conversion -> result "4294967295", ndigits_o=10, single done_o, toggles ignored.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for bin_to_bcd_seq: the master drives the value and the
// start request, the slave (converter) returns status and the formatted digits.
interface bin_to_bcd_seq_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
);
    logic [WIDTH-1:0]                 bin_i;
    logic                             start_i;
    logic                             busy_o;
    logic                             done_o;
    logic                             valid_o;
    logic                             ovf_o;
    logic [8*DIGITS-1:0]              digits_o;
    logic [$clog2(DIGITS+1)-1:0]      ndigits_o;

    modport master (
        output bin_i, start_i,
        input  busy_o, done_o, valid_o, ovf_o, digits_o, ndigits_o
    );

    modport slave (
        input  bin_i, start_i,
        output busy_o, done_o, valid_o, ovf_o, digits_o, ndigits_o
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-decimal converter, one input bit per clock,
// with ASCII/raw-BCD encoding, optional leading-zero blanking and overflow flag.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DIGITS   = 10,
    parameter int unsigned ASCII    = 1,
    parameter int unsigned BLANK_LZ = 0
) (
    input logic             clk_i,
    input logic             rst_ni,
    bin_to_bcd_seq_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned NW    = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;

    state_e                state_q, state_d;
    logic                  start_q;
    logic [WIDTH-1:0]      shreg_q, shreg_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic [8*DIGITS-1:0]   digits_q, digits_d;
    logic [NW-1:0]         ndigits_q, ndigits_d;

    logic                  accept;
    logic [4*DIGITS-1:0]   adj;
    logic [NW-1:0]         nsig;
    logic [8*DIGITS-1:0]   enc;
    logic [3:0]            adj_dig;
    logic [3:0]            enc_dig;

    // Datapath helpers: add-3 correction, significant-digit count, output encoding
    always_comb begin
        accept  = bus.start_i & ~start_q & (state_q == IDLE);
        adj     = '0;
        nsig    = NW'(1);
        enc     = '0;
        adj_dig = '0;
        enc_dig = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            adj_dig = bcd_q[4*i +: 4];
            adj[4*i +: 4] = (adj_dig >= 4'd5) ? adj_dig + 4'd3 : adj_dig;
            if (bcd_q[4*i +: 4] != 4'd0) begin
                nsig = NW'(i + 1);
            end
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
            enc_dig = bcd_q[4*i +: 4];
            if ((BLANK_LZ != 0) && (i >= 32'(nsig))) begin
                enc[8*i +: 8] = (ASCII != 0) ? 8'h20 : 8'h0F;
            end else begin
                enc[8*i +: 8] = (ASCII != 0) ? {4'h3, enc_dig} : {4'h0, enc_dig};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bcd_d     = bcd_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        digits_d  = digits_q;
        ndigits_d = ndigits_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d   = bus.bin_i;
                    bcd_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Bit leaving the top digit is a lost decimal carry
                bcd_d     = {adj[4*DIGITS-2:0], shreg_q[WIDTH-1]};
                ovf_acc_d = ovf_acc_q | adj[4*DIGITS-1];
                shreg_d   = shreg_q << 1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                digits_d  = enc;
                ndigits_d = nsig;
                ovf_d     = ovf_acc_q;
                done_d    = 1'b1;
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            shreg_q   <= '0;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            digits_q  <= '0;
            ndigits_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= bus.start_i;
            shreg_q   <= shreg_d;
            bcd_q     <= bcd_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            digits_q  <= digits_d;
            ndigits_q <= ndigits_d;
        end
    end

    assign bus.busy_o    = (state_q != IDLE);
    assign bus.done_o    = done_q;
    assign bus.valid_o   = valid_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.digits_o  = digits_q;
    assign bus.ndigits_o = ndigits_q;
endmodule
